// File: rtl/code_entry_pkg.sv
// Shared lock definitions: key codes, digit blank value and entry FSM states.
package code_entry_pkg;
  localparam int unsigned NUM_DIGITS  = 6;
  localparam logic [2:0]  COUNT_MAX   = 3'd6;
  localparam logic [3:0]  KEY_BKSP    = 4'hA;
  localparam logic [3:0]  KEY_CONF    = 4'hB;
  localparam logic [3:0]  KEY_CLR     = 4'hC;
  localparam logic [3:0]  DIGIT_BLANK = 4'hF;

  typedef enum logic {
    ST_ENTRY,
    ST_CHECK
  } state_t;
endpackage

// File: rtl/idle_timer.sv
// Restartable saturating inactivity counter; o_expire is high on its final count.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_run,
  output logic o_expire
);
  localparam int unsigned   TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_restart || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != T_LAST) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_expire = i_run && (r_cnt == T_LAST);
endmodule

// File: rtl/code_entry.sv
// Keypad digit collection: six-digit entry with editing, idle auto-clear and a
// fixed-length comparator check window after a valid confirm.
module code_entry
  import code_entry_pkg::*;
#(
  parameter int unsigned CHECK_LEN   = 4,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic [3:0] d5,
  output logic [3:0] d6,
  output logic [2:0] count,
  output logic       check,
  output logic       key_reject,
  output logic       timeout
);
  localparam int unsigned   CW       = $clog2(CHECK_LEN);
  localparam logic [CW-1:0] CHK_LAST = CW'(CHECK_LEN - 1);

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_dig     [NUM_DIGITS];
  logic [3:0]    w_dig_nxt [NUM_DIGITS];
  logic [2:0]    r_count, w_count_nxt, w_count_m1;
  logic [CW-1:0] r_chk, w_chk_nxt;
  logic          r_check, w_check_nxt;
  logic          r_rej, w_rej_nxt;
  logic          r_to, w_to_nxt;
  logic          w_clear;
  logic          w_run, w_expire;

  assign w_run      = (r_state == ST_ENTRY) && (r_count != '0);
  assign w_count_m1 = r_count - 3'd1;

  idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (key_valid),
    .i_run     (w_run),
    .o_expire  (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_dig_nxt   = r_dig;
    w_count_nxt = r_count;
    w_chk_nxt   = r_chk;
    w_check_nxt = r_check;
    w_rej_nxt   = 1'b0;
    w_to_nxt    = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      ST_ENTRY: begin
        // A key on the expiry cycle wins: the timer restarts and no timeout fires.
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (r_count < COUNT_MAX) begin
              w_dig_nxt[r_count] = key_code;
              w_count_nxt        = r_count + 3'd1;
            end else begin
              w_rej_nxt = 1'b1;
            end
          end else if (key_code == KEY_BKSP) begin
            if (r_count != '0) begin
              w_dig_nxt[w_count_m1] = DIGIT_BLANK;
              w_count_nxt           = w_count_m1;
            end else begin
              w_rej_nxt = 1'b1;
            end
          end else if (key_code == KEY_CLR) begin
            w_clear = 1'b1;
          end else if (key_code == KEY_CONF && r_count == COUNT_MAX) begin
            w_state_nxt = ST_CHECK;
            w_check_nxt = 1'b1;
            w_chk_nxt   = '0;
          end else begin
            w_rej_nxt = 1'b1;
          end
        end else if (w_expire) begin
          w_clear  = 1'b1;
          w_to_nxt = 1'b1;
        end
      end
      ST_CHECK: begin
        w_rej_nxt = key_valid;
        if (r_chk == CHK_LAST) begin
          w_state_nxt = ST_ENTRY;
          w_check_nxt = 1'b0;
          w_clear     = 1'b1;
        end else begin
          w_chk_nxt = r_chk + CW'(1);
        end
      end
      default: w_state_nxt = ST_ENTRY;
    endcase
    if (w_clear) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) w_dig_nxt[i] = DIGIT_BLANK;
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ENTRY;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) r_dig[i] <= DIGIT_BLANK;
      r_count <= '0;
      r_chk   <= '0;
      r_check <= 1'b0;
      r_rej   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dig   <= w_dig_nxt;
      r_count <= w_count_nxt;
      r_chk   <= w_chk_nxt;
      r_check <= w_check_nxt;
      r_rej   <= w_rej_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign d1         = r_dig[0];
  assign d2         = r_dig[1];
  assign d3         = r_dig[2];
  assign d4         = r_dig[3];
  assign d5         = r_dig[4];
  assign d6         = r_dig[5];
  assign count      = r_count;
  assign check      = r_check;
  assign key_reject = r_rej;
  assign timeout    = r_to;
endmodule

// File: tb/tb_code_entry.sv
// Directed and random key sequences checked every cycle against a queue-based model.
module tb_code_entry;
  localparam int unsigned CL = 4;
  localparam int unsigned TO = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] d1, d2, d3, d4, d5, d6;
  logic [2:0] count;
  logic       check, key_reject, timeout;

  int tests = 0;
  int fails = 0;

  int q[$];
  int chk_left = 0;
  int idle = 0;
  bit m_chk = 1'b0;
  bit m_rej = 1'b0;
  bit m_to = 1'b0;

  always #5 clk = ~clk;

  code_entry #(.CHECK_LEN(CL), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .d4         (d4),
    .d5         (d5),
    .d6         (d6),
    .count      (count),
    .check      (check),
    .key_reject (key_reject),
    .timeout    (timeout)
  );

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit v, input int c);
    m_rej = 1'b0;
    m_to  = 1'b0;
    if (rst) begin
      q.delete();
      m_chk = 1'b0;
      chk_left = 0;
      idle = 0;
    end else if (m_chk) begin
      if (v) m_rej = 1'b1;
      idle = 0;
      chk_left--;
      if (chk_left == 0) begin
        m_chk = 1'b0;
        q.delete();
      end
    end else if (v) begin
      idle = 0;
      if (c <= 9) begin
        if (q.size() < 6) q.push_back(c);
        else m_rej = 1'b1;
      end else if (c == 10) begin
        if (q.size() > 0) void'(q.pop_back());
        else m_rej = 1'b1;
      end else if (c == 12) begin
        q.delete();
      end else if (c == 11 && q.size() == 6) begin
        m_chk = 1'b1;
        chk_left = CL;
      end else begin
        m_rej = 1'b1;
      end
    end else if (q.size() > 0) begin
      if (idle == TO - 1) begin
        q.delete();
        m_to = 1'b1;
        idle = 0;
      end else begin
        idle++;
      end
    end else begin
      idle = 0;
    end
  endtask

  task automatic check_all();
    logic [3:0] dv[6];
    logic [3:0] ev;
    dv[0] = d1; dv[1] = d2; dv[2] = d3; dv[3] = d4; dv[4] = d5; dv[5] = d6;
    for (int i = 0; i < 6; i++) begin
      ev = (i < q.size()) ? 4'(q[i]) : 4'hF;
      cmp($sformatf("d%0d", i + 1), {4'h0, dv[i]}, {4'h0, ev});
    end
    cmp("count", {5'h0, count}, 8'(q.size()));
    cmp("check", {7'h0, check}, {7'h0, m_chk});
    cmp("key_reject", {7'h0, key_reject}, {7'h0, m_rej});
    cmp("timeout", {7'h0, timeout}, {7'h0, m_to});
  endtask

  task automatic step(input bit rn, input bit v, input logic [3:0] c);
    rst_n = rn;
    key_valid = v;
    key_code = c;
    @(posedge clk);
    model(!rn, v, int'(c));
    #1;
    check_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0);
  endtask

  task automatic fill6();
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 4'(i));
  endtask

  initial begin
    int r;
    int k;
    logic [3:0] c;
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    // full entry, confirm, check window
    fill6();
    step(1'b1, 1'b1, 4'hB);
    idle_n(6);
    // backspace editing and reject at zero
    step(1'b1, 1'b1, 4'h7);
    step(1'b1, 1'b1, 4'h8);
    step(1'b1, 1'b1, 4'h9);
    step(1'b1, 1'b1, 4'hA);
    step(1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b1, 4'hC);
    step(1'b1, 1'b1, 4'hA);
    idle_n(1);
    // overflow digit and short confirm
    fill6();
    step(1'b1, 1'b1, 4'h9);
    step(1'b1, 1'b1, 4'hC);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 4'(i));
    step(1'b1, 1'b1, 4'hB);
    step(1'b1, 1'b1, 4'hC);
    // timeout, then key on the expiry cycle
    step(1'b1, 1'b1, 4'h3);
    idle_n(11);
    step(1'b1, 1'b1, 4'h3);
    idle_n(9);
    step(1'b1, 1'b1, 4'h4);
    idle_n(3);
    step(1'b1, 1'b1, 4'hC);
    // key during check window; clear at count 5
    fill6();
    step(1'b1, 1'b1, 4'hB);
    step(1'b1, 1'b1, 4'h2);
    idle_n(4);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 4'(i));
    step(1'b1, 1'b1, 4'hC);
    // reset in the 2nd check cycle; invalid codes
    fill6();
    step(1'b1, 1'b1, 4'hB);
    idle_n(1);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hD);
    step(1'b1, 1'b1, 4'hE);
    step(1'b1, 1'b1, 4'hF);
    // random traffic
    for (int n = 0; n < 700; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else if (r < 5) begin
        idle_n(12);
      end else if (r < 45) begin
        step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      end else begin
        k = $urandom_range(0, 19);
        if (k < 11)      c = 4'($urandom_range(0, 9));
        else if (k < 14) c = 4'hA;
        else if (k < 17) c = 4'hB;
        else if (k < 18) c = 4'hC;
        else             c = 4'($urandom_range(13, 15));
        step(1'b1, 1'b1, c);
      end
    end
    key_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
